// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: platform interrupt source for the RV32IC core.
// The block has a free-running compare timer (id 0) and N_IRQ external lines
// (ids 1..N_IRQ). It latches pending sources and priority-selects one. The
// selected request is presented on int_req/int_num until the core acks it.
// A separate edge-detected path generates the one-cycle NMI pulse.
// Optional build macro: IRQ_LEVEL_EN. When it is defined, the external lines
// are level-sensitive and pend mirrors irq_i. The default build is
// edge-latched.
// "int" is a reserved word in SystemVerilog, so the request output is int_req.
module irq_timer_ctrl #(
  parameter int unsigned N_IRQ   = 4,
  parameter int unsigned IDW     = 3,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             en_tmr,
  input  logic [31:0]      limit,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             nmi_i,
  input  logic             ack,
  output logic             int_req,
  output logic [IDW-1:0]   int_num,
  output logic             nmi,
  output logic [31:0]      tmr_cnt
);

  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_HOLD
  } state_t;

  state_t           state, state_nx;
  logic             int_nx;
  logic [IDW-1:0]   num_nx;
  logic [HW-1:0]    hold_cnt, hold_nx;

  logic             tpend;
  logic [N_IRQ-1:0] pend;
  logic             clr_tmr;
  logic             tmr_run, tmr_wrap, tmr_fire;

  logic [N_IRQ:0]   elig;
  logic [IDW-1:0]   winner;
  logic             found;

  logic             prev_nmi;

  // Timer control decode. When limit is lowered below the count, the count
  // keeps rising, wraps at 2^32-1, and only then reaches the compare value.
  assign tmr_run  = en_tmr && (limit != 32'd0);
  assign tmr_wrap = (tmr_cnt == (limit - 32'd1));
  assign tmr_fire = tmr_run && tmr_wrap;

  // Timer counter and timer-pending flag. A new fire wins over an ack clear.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      tmr_cnt <= '0;
      tpend   <= 1'b0;
    end else begin
      if (tmr_run) begin
        tmr_cnt <= tmr_wrap ? '0 : tmr_cnt + 32'd1;
      end
      tpend <= tmr_fire | (tpend & ~clr_tmr);
    end
  end

`ifdef IRQ_LEVEL_EN
  // Level mode: the pending bits follow the lines; an ack never clears them.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= irq_i;
    end
  end
`else
  logic [N_IRQ-1:0] prev_irq;
  logic [N_IRQ-1:0] clr_ext;
  logic [N_IRQ-1:0] rise;

  assign rise = irq_i & ~prev_irq;

  // Ack clear for the external source currently being presented.
  always_comb begin
    clr_ext = '0;
    if ((state == S_PRESENT) && ack) begin
      for (int unsigned k = 0; k < N_IRQ; k++) begin
        if (int_num == IDW'(k + 1)) begin
          clr_ext[k] = 1'b1;
        end
      end
    end
  end

  // Edge latching. At reset the history loads the live lines, so a line that
  // is already high raises nothing. A set in the same cycle as a clear wins.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      pend     <= '0;
      prev_irq <= irq_i;
    end else begin
      pend     <= rise | (pend & ~clr_ext);
      prev_irq <= irq_i;
    end
  end
`endif

  // Timer clear: the ack applies to whichever source int_num names.
  assign clr_tmr = (state == S_PRESENT) && ack && (int_num == '0);

  // Eligible set and fixed-priority pick: the timer first, then the lowest line.
  assign elig = {pend & irq_mask, tpend};

  // Priority encoder over the eligible set (bit 0 = timer).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i <= N_IRQ; i++) begin
      if (!found && elig[i]) begin
        winner = IDW'(i);
        found  = 1'b1;
      end
    end
  end

  // Presentation FSM: next state, next registered outputs and holdoff count.
  always_comb begin
    state_nx = state;
    int_nx   = int_req;
    num_nx   = int_num;
    hold_nx  = hold_cnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          int_nx   = 1'b1;
          num_nx   = winner;
          state_nx = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ack) begin
          int_nx = 1'b0;
          if (HOLDOFF == 0) begin
            state_nx = S_IDLE;
          end else begin
            hold_nx  = HW'(HOLDOFF);
            state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        hold_nx = hold_cnt - HW'(1);
        if (hold_cnt == HW'(1)) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        int_nx   = 1'b0;
      end
    endcase
  end

  // FSM state register and registered request outputs.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state    <= S_IDLE;
      int_req  <= 1'b0;
      int_num  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      int_req  <= int_nx;
      int_num  <= num_nx;
      hold_cnt <= hold_nx;
    end
  end

  // NMI: one-cycle pulse on each rising edge of nmi_i, independent of the FSM.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      nmi      <= 1'b0;
      prev_nmi <= nmi_i;
    end else begin
      nmi      <= nmi_i & ~prev_nmi;
      prev_nmi <= nmi_i;
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed self-checking bench for irq_timer_ctrl (default edge-latched build).
module tb_irq_timer_ctrl;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        en_tmr;
  logic [31:0] limit;
  logic [3:0]  irq_i;
  logic [3:0]  irq_mask;
  logic        nmi_i;
  logic        ack;
  logic        int_req;
  logic [2:0]  int_num;
  logic        nmi;
  logic [31:0] tmr_cnt;

  int total = 0;
  int bad   = 0;

  irq_timer_ctrl #(.N_IRQ(4), .IDW(3), .HOLDOFF(2)) dut (
    .clk_i    (clk_i),
    .rst      (rst),
    .en_tmr   (en_tmr),
    .limit    (limit),
    .irq_i    (irq_i),
    .irq_mask (irq_mask),
    .nmi_i    (nmi_i),
    .ack      (ack),
    .int_req  (int_req),
    .int_num  (int_num),
    .nmi      (nmi),
    .tmr_cnt  (tmr_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en_tmr = 1'b1; limit = 32'd5; irq_i = '0;
    irq_mask = 4'b1111; nmi_i = 1'b0; ack = 1'b0;
    tick(2);
    chk("rst_int", int_req, 1'b0);
    chk("rst_num", int_num, 3'd0);
    chk("rst_nmi", nmi, 1'b0);
    chk("rst_cnt", tmr_cnt, 32'd0);

    // 1. Timer: the count wraps 4->0 at edge 5 and the request appears at edge 6.
    rst = 1'b0;
    tick(4);
    chk("t1_cnt4", tmr_cnt, 32'd4);
    tick();
    chk("t1_wrap_cnt", tmr_cnt, 32'd0);
    chk("t1_wrap_int", int_req, 1'b0);
    tick();
    chk("t1_fire_int", int_req, 1'b1);
    chk("t1_fire_num", int_num, 3'd0);
    chk("t1_fire_cnt", tmr_cnt, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_ack_int", int_req, 1'b0);
    tick(3);
    chk("t1_gap_int", int_req, 1'b0);
    tick();
    chk("t1_fire2_int", int_req, 1'b1);
    chk("t1_fire2_num", int_num, 3'd0);

    // 2. Priority: irq bits 1,2 edge together with the next timer fire.
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_ack_int", int_req, 1'b0);
    tick(2);
    chk("t2_cnt4", tmr_cnt, 32'd4);
    irq_i = 4'b0110;
    tick();
    chk("t2_pend_int", int_req, 1'b0);
    tick();
    chk("t2_p0_int", int_req, 1'b1);
    chk("t2_p0_num", int_num, 3'd0);
    ack = 1'b1; en_tmr = 1'b0; tick(); ack = 1'b0;
    chk("t2_hold_cnt", tmr_cnt, 32'd1);
    tick(2);
    chk("t2_gap0_int", int_req, 1'b0);
    tick();
    chk("t2_p2_int", int_req, 1'b1);
    chk("t2_p2_num", int_num, 3'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    tick(2);
    chk("t2_gap2_int", int_req, 1'b0);
    tick();
    chk("t2_p3_int", int_req, 1'b1);
    chk("t2_p3_num", int_num, 3'd3);
    ack = 1'b1; tick(); ack = 1'b0;
    irq_i = '0;
    tick(3);
    chk("t2_empty_int", int_req, 1'b0);

    // 3. Mask: a masked pulse stays pending and presents once unmasked.
    irq_mask = '0;
    irq_i = 4'b0001; tick(); irq_i = '0; tick();
    tick(10);
    chk("t3_masked_int", int_req, 1'b0);
    irq_mask = 4'b0001;
    tick();
    chk("t3_unmask_int", int_req, 1'b1);
    chk("t3_unmask_num", int_num, 3'd1);

    // 4. Collision: an ack of id 1 and a new irq_i[0] edge arrive in one cycle.
    ack = 1'b1; irq_i = 4'b0001; tick(); ack = 1'b0; irq_i = '0;
    chk("t4_ack_int", int_req, 1'b0);
    tick(2);
    chk("t4_gap_int", int_req, 1'b0);
    tick();
    chk("t4_re_int", int_req, 1'b1);
    chk("t4_re_num", int_num, 3'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    tick(3);
    chk("t4_empty_int", int_req, 1'b0);

    // 5. NMI while the timer request is presented.
    en_tmr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (int_req === 1'b1) break;
      tick();
    end
    chk("t5_wait_int", int_req, 1'b1);
    chk("t5_wait_num", int_num, 3'd0);
    nmi_i = 1'b1; tick();
    chk("t5_nmi_hi", nmi, 1'b1);
    chk("t5_int_keep", int_req, 1'b1);
    chk("t5_num_keep", int_num, 3'd0);
    tick();
    chk("t5_nmi_lo", nmi, 1'b0);
    chk("t5_int_keep2", int_req, 1'b1);
    ack = 1'b1; en_tmr = 1'b0; nmi_i = 1'b0; tick(); ack = 1'b0;
    chk("t5_ack_int", int_req, 1'b0);
    tick(3);

    // 6. Reset mid-PRESENT with irq_i[0] and nmi_i held high.
    irq_i = 4'b0001;
    tick(2);
    chk("t6_pres_int", int_req, 1'b1);
    chk("t6_pres_num", int_num, 3'd1);
    rst = 1'b1; nmi_i = 1'b1; tick();
    chk("t6_rst_int", int_req, 1'b0);
    chk("t6_rst_num", int_num, 3'd0);
    chk("t6_rst_nmi", nmi, 1'b0);
    chk("t6_rst_cnt", tmr_cnt, 32'd0);
    rst = 1'b0; en_tmr = 1'b1; limit = 32'd0;
    tick(4);
    chk("t6_quiet_int", int_req, 1'b0);
    chk("t6_quiet_nmi", nmi, 1'b0);
    chk("t6_lim0_cnt", tmr_cnt, 32'd0);
    irq_i = '0; tick();
    irq_i = 4'b0001; tick();
    chk("t6_edge_int", int_req, 1'b0);
    tick();
    chk("t6_new_int", int_req, 1'b1);
    chk("t6_new_num", int_num, 3'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t6_ack_int", int_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
